// File: rtl/fuente_main_pkg.sv
// Shared arqui definitions: word/counter widths, FSM encoding, pattern modes
// and the 6-bit LFSR (x^6 + x^5 + 1) step used by generators and checkers.
package arqui_pkg;

  localparam int WIDTH = 6;
  localparam int CNT_W = 5;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Feedback taps for x^6 + x^5 + 1: new bit = q[5] ^ q[4].
  localparam logic [5:0] LFSR_TAPS      = 6'b110000;
  // All-zero is the LFSR lock-up state, so a zero seed is replaced by this.
  localparam logic [5:0] LFSR_ZERO_SEED = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  function automatic logic [5:0] lfsr6_step(input logic [5:0] q);
    return {q[4:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fuente_main_if.sv
// Source -> main FIFO link. Valid/ready contract: a word on data_out is
// transferred in every cycle push_main is high (push_main is the valid, there
// is no per-word ready); pause_main is the FIFO's almost-full level and the
// source must stop pushing from the cycle after it samples pause_main high.
interface fuente_main_if #(
  parameter int DW = arqui_pkg::WIDTH
);
  logic [DW-1:0] data_out;
  logic          push_main;
  logic          pause_main;

  modport master (output data_out, output push_main, input pause_main);
  modport slave  (input data_out, input push_main, output pause_main);
endinterface

// File: rtl/fuente_main_lfsr6.sv
// 6-bit maximal-length LFSR with synchronous load; a zero seed loads 1.
module lfsr6 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] seed,
  output logic [5:0] q
);
  import arqui_pkg::*;

  // Load has priority over stepping so a new burst always starts at its seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_ZERO_SEED;
    end else if (load) begin
      q <= (seed == 6'd0) ? LFSR_ZERO_SEED : seed;
    end else if (en) begin
      q <= lfsr6_step(q);
    end
  end

endmodule

// File: rtl/fuente_main.sv
// Burst traffic source for the main FIFO: pushes num_words words of an
// incrementing or LFSR pattern, stalls on pause_main, aborts on error_in.
module fuente_main #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] base,
  input  logic [CNT_W-1:0] num_words,
  input  logic             error_in,
  fuente_main_if.master    fifo,
  output logic             busy,
  output logic             done,
  output logic             error_out,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [2:0]       dbg_state
);
  import arqui_pkg::*;

  state_t           state_q, state_d;
  logic             mode_q;
  logic [WIDTH-1:0] inc_q;
  logic [CNT_W-1:0] len_q;
  logic [5:0]       lfsr_q;
  logic [WIDTH-1:0] cur_word;
  logic             accept_start;
  logic             last_word;
  logic             push_d, busy_d, done_d, err_d;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign last_word    = ((sent_cnt + CNT_W'(1)) == len_q);
  assign cur_word     = (mode_q == MODE_LFSR) ? WIDTH'(lfsr_q) : inc_q;
  assign dbg_state    = state_q;

  lfsr6 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (push_d),
    .load  (accept_start),
    .seed  (base[5:0]),
    .q     (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state. HOLD resumes straight into a push when pause drops, so each
  // paused cycle costs exactly one cycle of burst time. Error beats pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_words == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (error_in)             state_d = ST_ABORT;
        else if (fifo.pause_main) state_d = ST_HOLD;
        else if (last_word)       state_d = ST_DONE;
        else                      state_d = ST_RUN;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_ABORT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; these values are registered below, one cycle behind state.
  always_comb begin
    push_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = error_out;
    unique case (state_q)
      ST_RUN, ST_HOLD: begin
        busy_d = !error_in;
        push_d = !error_in && !fifo.pause_main;
        err_d  = error_out | error_in;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs; data_out holds its last word between pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo.push_main <= 1'b0;
      fifo.data_out  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error_out      <= 1'b0;
      sent_cnt       <= '0;
    end else begin
      fifo.push_main <= push_d;
      busy           <= busy_d;
      done           <= done_d;
      error_out      <= err_d;
      if (push_d) begin
        fifo.data_out <= cur_word;
        sent_cnt      <= sent_cnt + CNT_W'(1);
      end else if (accept_start) begin
        sent_cnt <= '0;
      end
    end
  end

  // Burst parameters latched on an accepted start; incrementing word advances per push.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_INC;
      inc_q  <= '0;
      len_q  <= '0;
    end else if (accept_start) begin
      mode_q <= mode;
      inc_q  <= base;
      len_q  <= num_words;
    end else if (push_d) begin
      inc_q <= inc_q + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fuente_main.sv
// Bench for fuente_main: directed and random bursts, scoreboard of expected words.
module tb_fuente_main;
  import arqui_pkg::*;

  localparam int W  = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, start, mode, error_in;
  logic [W-1:0]  base;
  logic [CW-1:0] num_words;
  logic          busy, done, error_out;
  logic [CW-1:0] sent_cnt;
  logic [2:0]    dbg_state;

  fuente_main_if fifo_if ();

  fuente_main #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .num_words (num_words),
    .error_in  (error_in),
    .fifo      (fifo_if),
    .busy      (busy),
    .done      (done),
    .error_out (error_out),
    .sent_cnt  (sent_cnt),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] mon_exp;
  int push_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference pattern: word k of a burst, straight from the pattern rules.
  function automatic logic [W-1:0] ref_word(input logic m, input logic [W-1:0] b, input int k);
    int s;
    if (m == MODE_INC) return W'((int'(b) + k) % 64);
    s = (b == '0) ? 1 : int'(b);
    for (int i = 0; i < k; i++) s = ((s * 2) % 64) + (((s / 32) ^ (s / 16)) % 2);
    return W'(s);
  endfunction

  // Monitor: compares every pushed word against the scoreboard queue.
  always @(negedge clk) begin
    if (fifo_if.push_main === 1'b1) begin
      push_cnt++;
      obs_q.push_back(fifo_if.data_out);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_push: got %0d want no push", fifo_if.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_if.data_out !== mon_exp) begin
          bad++;
          $display("FAIL push_word: got %0d want %0d", fifo_if.data_out, mon_exp);
        end
      end
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    error_in = 1'b0;
    fifo_if.pause_main = 1'b0;
    tick();
    tick();
    check("rst_push", int'(fifo_if.push_main), 0);
    check("rst_data", int'(fifo_if.data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error_out), 0);
    check("rst_sent", int'(sent_cnt), 0);
    check("rst_state", int'(dbg_state), 0);
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  // One burst: queue expectations, launch, optionally pause/restart, wait for done.
  task automatic run_burst(input logic m, input logic [W-1:0] b, input int n,
                           input int pause_after, input int pause_len,
                           input bit rand_pause, input int restart_at);
    int p0, d0, pushes, pause_left;
    bit pause_fired, restart_fired, got_done;
    for (int k = 0; k < n; k++) exp_q.push_back(ref_word(m, b, k));
    busy_cnt = 0;
    p0 = push_cnt;
    d0 = done_cnt;
    pause_left = 0;
    pause_fired = 0;
    restart_fired = 0;
    got_done = 0;
    start = 1'b1;
    mode = m;
    base = b;
    num_words = CW'(n);
    tick();
    start = 1'b0;
    mode = ~m;
    base = W'($urandom_range(0, 63));
    num_words = CW'($urandom_range(0, 31));
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      tick();
      if (done_cnt > d0) begin
        got_done = 1;
      end else begin
        pushes = push_cnt - p0;
        if (pause_after > 0 && pushes == pause_after && !pause_fired) begin
          pause_fired = 1;
          pause_left = pause_len;
        end
        if (pause_left > 0) begin
          fifo_if.pause_main = 1'b1;
          pause_left--;
        end else begin
          fifo_if.pause_main = rand_pause ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (restart_at > 0 && pushes == restart_at && !restart_fired) begin
          restart_fired = 1;
          start = 1'b1;
          mode = 1'($urandom_range(0, 1));
          base = W'($urandom_range(0, 63));
        end else begin
          start = 1'b0;
        end
      end
    end
    fifo_if.pause_main = 1'b0;
    start = 1'b0;
    check("done_seen", int'(got_done), 1);
    check("words_left", exp_q.size(), 0);
    exp_q.delete();
    check("push_count", push_cnt - p0, n);
    check("sent_cnt", int'(sent_cnt), n);
    if (!rand_pause) check("busy_cycles", busy_cnt, n + pause_len);
    tick();
    check("done_width", done_cnt - d0, 1);
    check("done_low", int'(done), 0);
  endtask

  initial begin
    logic [W-1:0] seed;
    logic [W-1:0] all_q[$];
    int p0, d0, cnt;
    bit seen [64];

    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    base = '0;
    num_words = '0;
    error_in = 1'b0;
    fifo_if.pause_main = 1'b0;
    do_reset();

    // Incrementing from 44, then wrap through 63.
    run_burst(MODE_INC, 6'd44, 5, 0, 0, 0, 0);
    run_burst(MODE_INC, 6'd62, 4, 0, 0, 0, 0);

    // Backpressure for 3 cycles after the 2nd push.
    run_burst(MODE_INC, W'($urandom_range(0, 63)), 8, 2, 3, 0, 0);

    // LFSR with seed 0 starts at 1.
    obs_q.delete();
    run_burst(MODE_LFSR, 6'd0, 20, 0, 0, 0, 0);
    check("lfsr_first", int'(obs_q[0]), 1);

    // LFSR period: 63 words over chained bursts, then the 64th equals the first.
    seed = W'($urandom_range(1, 63));
    obs_q.delete();
    run_burst(MODE_LFSR, seed, 31, 0, 0, 0, 0);
    run_burst(MODE_LFSR, ref_word(MODE_LFSR, seed, 31), 31, 0, 0, 0, 0);
    run_burst(MODE_LFSR, ref_word(MODE_LFSR, seed, 62), 2, 0, 0, 0, 0);
    all_q = obs_q;
    for (int i = 0; i < 64; i++) seen[i] = 0;
    cnt = 0;
    for (int i = 0; i < 63 && i < all_q.size(); i++) begin
      if (all_q[i] != '0 && !seen[all_q[i]]) cnt++;
      seen[all_q[i]] = 1;
    end
    check("lfsr_distinct", cnt, 63);
    if (all_q.size() == 64) check("lfsr_period", int'(all_q[63]), int'(seed));
    else check("lfsr_len", all_q.size(), 64);

    // Zero-length burst: done only.
    run_burst(MODE_INC, 6'd7, 0, 0, 0, 0, 0);

    // start mid-burst must not disturb the running sequence.
    run_burst(MODE_LFSR, W'($urandom_range(0, 63)), 12, 0, 0, 0, 4);

    // error_in while idle is ignored.
    error_in = 1'b1;
    tick();
    tick();
    error_in = 1'b0;
    check("idle_error_ignored", int'(error_out), 0);
    check("idle_error_state", int'(dbg_state), int'(ST_IDLE));

    // Random bursts with random backpressure.
    for (int r = 0; r < 15; r++)
      run_burst(1'($urandom_range(0, 1)), W'($urandom_range(0, 63)),
                $urandom_range(1, 31), 0, 0, 1, 0);

    // Abort after 3 pushes.
    p0 = push_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) exp_q.push_back(ref_word(MODE_INC, 6'd20, k));
    start = 1'b1;
    mode = MODE_INC;
    base = 6'd20;
    num_words = 5'd10;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && (push_cnt - p0) < 3; cyc++) tick();
    error_in = 1'b1;
    tick();
    error_in = 1'b0;
    repeat (3) tick();
    check("abort_pushes", push_cnt - p0, 3);
    check("abort_error", int'(error_out), 1);
    check("abort_busy", int'(busy), 0);
    start = 1'b1;
    base = 6'd1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_start_ignored", push_cnt - p0, 3);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sticky", int'(error_out), 1);
    check("abort_words_left", exp_q.size(), 0);
    do_reset();

    // Normal operation resumes after reset.
    run_burst(MODE_INC, W'($urandom_range(0, 63)), 6, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
